// File: rtl/escalonador_so.sv
// Round-robin OS controller: boots from BIOS, swaps programs from HD tracks into instruction RAM
// and saves/restores PCs. Define SO_CHECKSUM_EN to verify each load (needs SETOR_W >= clog2(PROG_WORDS+1)).
module escalonador_so #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int PROG_WORDS = 64,
  parameter int NUM_PROGS  = 4,
  parameter int TRILHA_W   = 4,
  parameter int SETOR_W    = 6,
  parameter int QUANTUM    = 256,
  localparam int PID_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt_cpu,
  input  logic [ADDR_W-1:0]   cpu_pc,
  output logic                hd_rd_en,
  output logic [TRILHA_W-1:0] hd_trilha,
  output logic [SETOR_W-1:0]  hd_setor,
  input  logic [DATA_W-1:0]   hd_dado,
  input  logic                hd_valido,
  output logic                mi_we,
  output logic [ADDR_W-1:0]   mi_ender,
  output logic [DATA_W-1:0]   mi_dado,
  output logic                sel_bios,
  output logic                bloq_cpu,
  output logic                pc_load,
  output logic [ADDR_W-1:0]   pc_valor,
  output logic [PID_W-1:0]    prog_atual,
  output logic                ocioso,
  output logic                erro_carga
);

`ifdef SO_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  localparam int CNT_W = $clog2(QUANTUM);

  typedef enum logic [2:0] {
    S_BIOS, S_SELECIONA, S_REQ, S_ESCREVE, S_RESTAURA, S_EXECUTA, S_FIM
  } state_t;

  state_t               state;
  logic [PID_W-1:0]     id;
  logic                 primeira;
  logic                 residente;
  logic [SETOR_W-1:0]   word;
  logic [DATA_W-1:0]    acc;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_PROGS-1:0] done;
  logic [ADDR_W-1:0]    saved_pc [NUM_PROGS];

  logic                 sel_found;
  logic [PID_W-1:0]     sel_id;
  logic                 eh_checksum;
  int                   cand;

  // Next unfinished program: from id 0 right after BIOS, else the one after the last selected.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = 0;
    for (int k = 0; k < NUM_PROGS; k++) begin
      cand = primeira ? k : (int'(id) + 1 + k) % NUM_PROGS;
      if (!sel_found && !done[PID_W'(cand)]) begin
        sel_found = 1'b1;
        sel_id    = PID_W'(cand);
      end
    end
  end

  assign eh_checksum = CK_EN && (word == SETOR_W'(PROG_WORDS));

  // NOTE: all state and outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_BIOS;
      sel_bios   <= 1'b1;
      bloq_cpu   <= 1'b0;
      hd_rd_en   <= 1'b0;
      hd_trilha  <= '0;
      hd_setor   <= '0;
      mi_we      <= 1'b0;
      mi_ender   <= '0;
      mi_dado    <= '0;
      pc_load    <= 1'b0;
      pc_valor   <= '0;
      prog_atual <= '0;
      ocioso     <= 1'b0;
      erro_carga <= 1'b0;
      id         <= '0;
      primeira   <= 1'b0;
      residente  <= 1'b0;
      word       <= '0;
      acc        <= '0;
      cnt        <= '0;
      done       <= '0;
      // NOTE: this small table is reset on purpose: a program's first run must restore PC 0.
      for (int i = 0; i < NUM_PROGS; i++) saved_pc[i] <= '0;
    end else begin
      mi_we   <= 1'b0;
      pc_load <= 1'b0;
      case (state)
        S_BIOS: if (halt_cpu) begin
          state    <= S_SELECIONA;
          primeira <= 1'b1;
          sel_bios <= 1'b0;
          bloq_cpu <= 1'b1;
        end
        S_SELECIONA: begin
          primeira <= 1'b0;
          if (!sel_found) begin
            state  <= S_FIM;
            ocioso <= 1'b1;
          end else begin
            id <= sel_id;
            if (residente && sel_id == prog_atual) begin
              state    <= S_EXECUTA;
              bloq_cpu <= 1'b0;
              cnt      <= '0;
            end else begin
              state     <= S_REQ;
              word      <= '0;
              acc       <= '0;
              hd_rd_en  <= 1'b1;
              hd_trilha <= TRILHA_W'(sel_id);
              hd_setor  <= '0;
            end
          end
        end
        S_REQ: if (hd_valido) begin
          hd_rd_en <= 1'b0;
          if (!eh_checksum) begin
            state    <= S_ESCREVE;
            mi_we    <= 1'b1;
            mi_ender <= ADDR_W'(word);
            mi_dado  <= hd_dado;
            acc      <= acc ^ hd_dado;
          end else if (hd_dado == acc) begin
            state      <= S_RESTAURA;
            pc_load    <= 1'b1;
            pc_valor   <= saved_pc[id];
            prog_atual <= id;
            residente  <= 1'b1;
          end else begin
            // RAM now holds a partial image, so nothing is resident any more.
            state      <= S_SELECIONA;
            done[id]   <= 1'b1;
            erro_carga <= 1'b1;
            residente  <= 1'b0;
          end
        end
        S_ESCREVE: begin
          if (word == SETOR_W'(PROG_WORDS - 1) && !CK_EN) begin
            state      <= S_RESTAURA;
            pc_load    <= 1'b1;
            pc_valor   <= saved_pc[id];
            prog_atual <= id;
            residente  <= 1'b1;
          end else begin
            state    <= S_REQ;
            word     <= word + 1'b1;
            hd_rd_en <= 1'b1;
            hd_setor <= word + 1'b1;
          end
        end
        S_RESTAURA: begin
          state    <= S_EXECUTA;
          bloq_cpu <= 1'b0;
          cnt      <= '0;
        end
        S_EXECUTA: begin
          cnt <= cnt + 1'b1;
          if (halt_cpu) begin
            done[id] <= 1'b1;
            state    <= S_SELECIONA;
            bloq_cpu <= 1'b1;
          end else if (cnt == CNT_W'(QUANTUM - 1)) begin
            saved_pc[id] <= cpu_pc;
            cnt          <= '0;
            state        <= S_SELECIONA;
            bloq_cpu     <= 1'b1;
          end
        end
        S_FIM: ;
        default: state <= S_BIOS;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_so.sv
// Randomized bench for escalonador_so: HD and CPU models drive stimulus, a reference scheduler
// predicts RAM writes / PC restores / idle into a queue, and a monitor checks what the DUT presents.
module tb_escalonador_so;
  localparam int DATA_W = 32, ADDR_W = 6, PW = 64, NP = 4, TRILHA_W = 4, SETOR_W = 7, Q = 16;
  localparam int BAD = 2;
`ifdef SO_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                halt_cpu = 1'b0;
  logic [ADDR_W-1:0]   cpu_pc = '0;
  logic                hd_rd_en;
  logic [TRILHA_W-1:0] hd_trilha;
  logic [SETOR_W-1:0]  hd_setor;
  logic [DATA_W-1:0]   hd_dado = '0;
  logic                hd_valido = 1'b0;
  logic                mi_we;
  logic [ADDR_W-1:0]   mi_ender;
  logic [DATA_W-1:0]   mi_dado;
  logic                sel_bios, bloq_cpu, pc_load, ocioso, erro_carga;
  logic [ADDR_W-1:0]   pc_valor;
  logic [1:0]          prog_atual;

  escalonador_so #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_WORDS(PW), .NUM_PROGS(NP),
    .TRILHA_W(TRILHA_W), .SETOR_W(SETOR_W), .QUANTUM(Q)
  ) dut (
    .clk(clk), .reset(reset), .halt_cpu(halt_cpu), .cpu_pc(cpu_pc),
    .hd_rd_en(hd_rd_en), .hd_trilha(hd_trilha), .hd_setor(hd_setor),
    .hd_dado(hd_dado), .hd_valido(hd_valido),
    .mi_we(mi_we), .mi_ender(mi_ender), .mi_dado(mi_dado),
    .sel_bios(sel_bios), .bloq_cpu(bloq_cpu), .pc_load(pc_load), .pc_valor(pc_valor),
    .prog_atual(prog_atual), .ocioso(ocioso), .erro_carga(erro_carga)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hd_word_raw(int t, int s);
    return ((t + 1) * 32'h0100_0193) ^ (s * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Track contents; sector PW holds the checksum, deliberately wrong on track BAD.
  function automatic logic [31:0] hd_word(int t, int s);
    logic [31:0] x;
    if (s < PW) return hd_word_raw(t, s);
    x = '0;
    for (int w = 0; w < PW; w++) x ^= hd_word_raw(t, w);
    return (t == BAD) ? (x ^ 32'h1) : x;
  endfunction

  // Scoreboard and reference scheduler state
  typedef enum int {EV_WR, EV_PC, EV_FIM} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          addr;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

  bit m_done[NP];
  int m_saved[NP];
  int m_res, m_cur;
  bit m_res_v, m_same, m_err;
  bit mon_en = 1'b0;
  bit ocioso_seen = 1'b0;

  // Decide which program runs next and queue every observable effect of getting it running.
  task automatic schedule(input int from_id, input bit from_bios);
    int nxt, base;
    bit first;
    base  = from_id;
    first = from_bios;
    m_same = 1'b0;
    forever begin
      nxt = -1;
      for (int k = 0; k < NP; k++)
        if (nxt < 0 && !m_done[first ? k : (base + 1 + k) % NP]) nxt = first ? k : (base + 1 + k) % NP;
      if (nxt < 0) begin
        exp_q.push_back('{EV_FIM, 0, 32'h0});
        m_cur = -1;
        return;
      end
      m_cur = nxt;
      if (m_res_v && nxt == m_res) begin
        m_same = 1'b1;
        return;
      end
      for (int w = 0; w < PW; w++) exp_q.push_back('{EV_WR, w, hd_word(nxt, w)});
      if (CK_EN && nxt == BAD) begin
        m_done[nxt] = 1'b1;
        m_res_v = 1'b0;
        m_err = 1'b1;
        base = nxt;
        first = 1'b0;
      end else begin
        exp_q.push_back('{EV_PC, m_saved[nxt], 32'(nxt)});
        m_res = nxt;
        m_res_v = 1'b1;
        return;
      end
    end
  endtask

  // HD model: random latency (often 5 cycles), stability checks while waiting, stray hd_valido otherwise
  initial begin
    bit                  pend;
    int                  delay_left;
    logic [TRILHA_W-1:0] t_lat;
    logic [SETOR_W-1:0]  s_lat;
    pend = 1'b0;
    delay_left = 0;
    t_lat = '0;
    s_lat = '0;
    forever begin
      @(negedge clk);
      hd_valido = 1'b0;
      if (!reset) begin
        pend = 1'b0;
      end else if (pend || hd_rd_en) begin
        if (!pend) begin
          pend = 1'b1;
          t_lat = hd_trilha;
          s_lat = hd_setor;
          delay_left = ($urandom_range(0, 3) == 0) ? 5 : $urandom_range(0, 2);
        end else begin
          check("hd_rd_en held while waiting", hd_rd_en, 1);
          check("hd_trilha stable", hd_trilha, t_lat);
          check("hd_setor stable", hd_setor, s_lat);
          check("mi_we quiet while waiting", mi_we, 0);
        end
        if (delay_left == 0) begin
          hd_valido = 1'b1;
          hd_dado = hd_word(int'(t_lat), int'(s_lat));
          pend = 1'b0;
        end else begin
          delay_left--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        hd_valido = 1'b1;
        hd_dado = $urandom;
      end
    end
  end

  // Monitor: every RAM write, PC restore and idle entry must match the head of the queue
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en && reset) begin
        if (mi_we) begin
          if (exp_q.size() == 0) check("unexpected mi_we", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("event kind at mi_we", e.kind, EV_WR);
            check("mi_ender", mi_ender, e.addr);
            check("mi_dado", mi_dado, e.data);
          end
        end
        if (pc_load) begin
          if (exp_q.size() == 0) check("unexpected pc_load", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("event kind at pc_load", e.kind, EV_PC);
            check("pc_valor", pc_valor, e.addr);
            check("prog_atual at pc_load", prog_atual, e.data);
          end
        end
        if (ocioso && !ocioso_seen) begin
          ocioso_seen = 1'b1;
          if (exp_q.size() == 0) check("unexpected ocioso", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("event kind at ocioso", e.kind, EV_FIM);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    check("watchdog", 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int n_left[NP];
    int unfinished, h, run_len, wait_len, n_slices;
    bit will_halt, forced_single, first_halt_done, first_save_done, timed_out;
    logic [ADDR_W-1:0] pc_v;
    h = 0;
    forced_single = 1'b0;
    first_halt_done = 1'b0;
    first_save_done = 1'b0;
    timed_out = 1'b0;
    for (int p = 0; p < NP; p++) begin
      m_done[p] = 1'b0;
      m_saved[p] = 0;
      n_left[p] = $urandom_range(0, 2);
    end
    m_res = 0; m_res_v = 1'b0; m_cur = 0; m_err = 1'b0; m_same = 1'b0;

    #2 reset = 1'b0;
    #1;
    check("reset sel_bios", sel_bios, 1);
    check("reset bloq_cpu", bloq_cpu, 0);
    check("reset hd_rd_en", hd_rd_en, 0);
    check("reset mi_we", mi_we, 0);
    check("reset pc_load", pc_load, 0);
    check("reset ocioso", ocioso, 0);
    check("reset erro_carga", erro_carga, 0);
    check("reset prog_atual", prog_atual, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    check("BIOS sel_bios", sel_bios, 1);
    check("BIOS bloq_cpu", bloq_cpu, 0);

    schedule(0, 1'b1);
    halt_cpu = 1'b1;
    @(negedge clk);
    halt_cpu = 1'b0;

    n_slices = 0;
    while (n_slices < 64) begin
      wait_len = 0;
      while ((bloq_cpu || sel_bios) && !ocioso && wait_len < 3000) begin
        @(negedge clk);
        wait_len++;
      end
      if (wait_len >= 3000) begin
        check("wait for EXECUTA timed out", 1, 0);
        timed_out = 1'b1;
        break;
      end
      if (ocioso) break;
      if (m_same) check("same-program resume latency", wait_len, 1);
      check("prog_atual while executing", prog_atual, m_cur);

      unfinished = 0;
      for (int p = 0; p < NP; p++) if (!m_done[p]) unfinished++;
      if (unfinished == 1 && !forced_single) begin
        will_halt = 1'b0;
        forced_single = 1'b1;
      end else if (n_left[m_cur] == 0) begin
        will_halt = 1'b1;
        h = (!first_halt_done || $urandom_range(0, 2) == 0) ? Q - 1 : $urandom_range(0, Q - 2);
        first_halt_done = 1'b1;
      end else begin
        will_halt = 1'b0;
        n_left[m_cur]--;
      end
      pc_v = first_save_done ? ADDR_W'($urandom_range(1, 63)) : 6'h12;
      cpu_pc = pc_v;

      run_len = 0;
      for (int i = 0; i <= Q + 1; i++) begin
        if (bloq_cpu) break;
        halt_cpu = will_halt && (i == h);
        run_len++;
        @(negedge clk);
      end
      halt_cpu = 1'b0;
      check("slice length", run_len, will_halt ? h + 1 : Q);

      if (will_halt) m_done[m_cur] = 1'b1;
      else begin
        m_saved[m_cur] = int'(pc_v);
        first_save_done = 1'b1;
      end
      schedule(m_cur, 1'b0);
      n_slices++;
    end

    if (!timed_out) begin
      check("ocioso at end", ocioso, 1);
      check("bloq_cpu in FIM", bloq_cpu, 1);
      check("sel_bios in FIM", sel_bios, 0);
      repeat (3) @(negedge clk);
      check("ocioso held", ocioso, 1);
      check("scoreboard drained", exp_q.size(), 0);
      check("erro_carga", erro_carga, m_err);
    end

    // Asynchronous reset in the middle of a load
    mon_en = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("ocioso cleared by reset", ocioso, 0);
    @(negedge clk);
    halt_cpu = 1'b1;
    @(negedge clk);
    halt_cpu = 1'b0;
    wait_len = 0;
    while (!(hd_rd_en && hd_setor == 7'd10) && wait_len < 2000) begin
      @(negedge clk);
      wait_len++;
    end
    check("reached word 10", wait_len < 2000, 1);
    #2 reset = 1'b0;
    #1;
    check("async reset sel_bios", sel_bios, 1);
    check("async reset bloq_cpu", bloq_cpu, 0);
    check("async reset hd_rd_en", hd_rd_en, 0);
    check("async reset hd_setor", hd_setor, 0);
    check("async reset mi_we", mi_we, 0);
    check("async reset pc_load", pc_load, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("BIOS after reset sel_bios", sel_bios, 1);
    check("BIOS after reset hd_rd_en", hd_rd_en, 0);
    check("BIOS after reset bloq_cpu", bloq_cpu, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
